// File: rtl/ledtest_count_gen_if.sv
// Board-side bundle of the LED/7-segment test source: raw switch and
// pushbutton pins going in, count/direction/status going out to the decoder.
interface ledtest_count_gen_if;
    logic       dir_sw;
    logic       run_btn_n;
    logic       step_btn_n;
    logic [3:0] count;
    logic       direction;
    logic       running;
    logic       tick;

    // Board / stimulus side: drives the raw pins, observes the results.
    modport master (
        output dir_sw,
        output run_btn_n,
        output step_btn_n,
        input  count,
        input  direction,
        input  running,
        input  tick
    );

    // Counter generator side.
    modport slave (
        input  dir_sw,
        input  run_btn_n,
        input  step_btn_n,
        output count,
        output direction,
        output running,
        output tick
    );
endinterface

// File: rtl/ledtest_count_gen.sv
// Count source for the LED/7-segment test: synchronises and debounces the
// board switch and buttons, then steps a 4-bit up/down counter at a
// prescaled rate with run/pause and single-step control. Single clock domain.
module ledtest_count_gen #(
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    ledtest_count_gen_if.slave   io
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    // Channel indices into the synchroniser/debouncer vectors.
    localparam int N_IN    = 3;
    localparam int CH_DIR  = 0;
    localparam int CH_RUN  = 1;
    localparam int CH_STEP = 2;
    // Idle level per channel: switch low, buttons released (high).
    localparam logic [2:0] IN_IDLE = 3'b110;

    // One step of the 4-bit modulo counter in the given direction.
    function automatic logic [3:0] step_value(input logic [3:0] value, input logic down);
        logic [3:0] next_v;
        if (down) begin
            next_v = value - 4'd1;
        end else begin
            next_v = value + 4'd1;
        end
        return next_v;
    endfunction

    logic [2:0]    raw_s;
    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    logic [2:0]    db_r;
    logic [DW-1:0] db_cnt_r [N_IN];
    logic [2:0]    fire_s;

    logic          dir_change_s;
    logic          run_press_s;
    logic          step_press_s;
    logic          auto_step_s;
    logic          manual_step_s;
    logic          do_step_s;

    logic [3:0]    count_r;
    logic          running_r;
    logic          tick_r;
    logic [PW-1:0] presc_r;

    assign raw_s = {io.step_btn_n, io.run_btn_n, io.dir_sw};

    // Two-flop synchroniser on every raw board input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= IN_IDLE;
            sync2_r <= IN_IDLE;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // A debouncer accepts its sample on the edge where it has differed long enough.
    always_comb begin
        fire_s = 3'b000;
        for (int i = 0; i < N_IN; i++) begin
            if ((sync2_r[i] != db_r[i]) && (db_cnt_r[i] == DB_LAST)) begin
                fire_s[i] = 1'b1;
            end else begin
                fire_s[i] = 1'b0;
            end
        end
    end

    // Debouncers: count consecutive differing samples, adopt the sample when the run is long enough.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (rst) begin
                db_r[i]     <= IN_IDLE[i];
                db_cnt_r[i] <= '0;
            end else if (sync2_r[i] == db_r[i]) begin
                db_cnt_r[i] <= '0;
            end else if (db_cnt_r[i] == DB_LAST) begin
                db_r[i]     <= sync2_r[i];
                db_cnt_r[i] <= '0;
            end else begin
                db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
            end
        end
    end

    // Decode press/direction events and decide whether a step happens this edge.
    always_comb begin
        dir_change_s  = fire_s[CH_DIR];
        // A press is the debounced button falling; releases carry no event.
        run_press_s   = fire_s[CH_RUN]  & ~sync2_r[CH_RUN];
        step_press_s  = fire_s[CH_STEP] & ~sync2_r[CH_STEP];
        // A direction change restarts the step period, so it swallows any coinciding step.
        auto_step_s   = running_r && (presc_r == PRESC_LAST) && !dir_change_s;
        manual_step_s = !running_r && step_press_s && !run_press_s && !dir_change_s;
        do_step_s     = auto_step_s || manual_step_s;
    end

    // Counter, prescaler, run/pause state and the step tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= 4'd0;
            running_r <= 1'b1;
            tick_r    <= 1'b0;
            presc_r   <= '0;
        end else begin
            tick_r <= do_step_s;
            if (do_step_s) begin
                count_r <= step_value(count_r, db_r[CH_DIR]);
            end else begin
                count_r <= count_r;
            end
            if (run_press_s) begin
                running_r <= ~running_r;
            end else begin
                running_r <= running_r;
            end
            // Prescaler freezes while paused so a resume continues the same period.
            if (dir_change_s) begin
                presc_r <= '0;
            end else if (running_r) begin
                if (presc_r == PRESC_LAST) begin
                    presc_r <= '0;
                end else begin
                    presc_r <= presc_r + PW'(1);
                end
            end else begin
                presc_r <= presc_r;
            end
        end
    end

    assign io.count     = count_r;
    assign io.direction = db_r[CH_DIR];
    assign io.running   = running_r;
    assign io.tick      = tick_r;

endmodule

// File: tb/tb_ledtest_count_gen.sv
// Bench for ledtest_count_gen with TICK_DIV=4, DEBOUNCE_CYCLES=3: a table of
// hand-derived checkpoints, a hand-written wrap sequence, then random pin
// activity, all while a behavioural model is compared every cycle.
module tb_ledtest_count_gen;

    localparam int TD = 4;
    localparam int DC = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ledtest_count_gen_if bus ();

    ledtest_count_gen #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_count;
    int m_presc;
    bit m_dir;
    bit m_run;
    bit m_tick;
    bit m_db  [3];
    bit raw_h [3][4];   // raw_h[ch][k] = raw pin sampled k+1 edges ago

    typedef struct {
        bit rst;
        bit dir_sw;
        bit run_n;
        bit step_n;
        int ncyc;
        int exp_count;
        bit exp_dir;
        bit exp_run;
        bit exp_tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit r, input bit d, input bit rn, input bit sn, input int n,
                           input int ec, input bit ed, input bit er, input bit et);
        vec_t v;
        v.rst = r; v.dir_sw = d; v.run_n = rn; v.step_n = sn; v.ncyc = n;
        v.exp_count = ec; v.exp_dir = ed; v.exp_run = er; v.exp_tick = et;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit idle_of(input int ch);
        return (ch == 0) ? 1'b0 : 1'b1;
    endfunction

    // Apply the rules for one rising edge, using the pin values present before it.
    task automatic model_edge();
        bit raw [3];
        bit acc [3];
        bit smp [3];
        bit dir_chg, run_p, step_p, term, stp;
        raw[0] = bus.dir_sw;
        raw[1] = bus.run_btn_n;
        raw[2] = bus.step_btn_n;
        if (rst) begin
            m_count = 0; m_presc = 0; m_run = 1'b1; m_tick = 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                m_db[ch] = idle_of(ch);
                for (int k = 0; k < 4; k++) raw_h[ch][k] = idle_of(ch);
            end
        end else begin
            // The debouncer sees the pin two edges late; it accepts once the
            // last DC samples it saw all disagree with the accepted level.
            for (int ch = 0; ch < 3; ch++) begin
                smp[ch] = raw_h[ch][1];
                acc[ch] = (raw_h[ch][1] != m_db[ch]) && (raw_h[ch][2] != m_db[ch]) &&
                          (raw_h[ch][3] != m_db[ch]);
            end
            dir_chg = acc[0];
            run_p   = acc[1] && !smp[1];
            step_p  = acc[2] && !smp[2];
            term    = m_run && (m_presc == TD - 1);
            stp     = !dir_chg && (term || (!m_run && step_p && !run_p));
            if (stp) m_count = m_dir ? (m_count + 15) % 16 : (m_count + 1) % 16;
            m_tick = stp;
            if (dir_chg) m_presc = 0;
            else if (m_run) m_presc = (m_presc + 1) % TD;
            if (run_p) m_run = !m_run;
            for (int ch = 0; ch < 3; ch++) begin
                if (acc[ch]) m_db[ch] = smp[ch];
                for (int k = 3; k > 0; k--) raw_h[ch][k] = raw_h[ch][k-1];
                raw_h[ch][0] = raw[ch];
            end
        end
        m_dir = m_db[0];
    endtask

    // One clock: advance the model at the edge, compare just after it.
    task automatic cycle();
        logic [6:0] exp_v;
        @(posedge clk);
        model_edge();
        #1;
        exp_v = {4'(m_count), m_dir, m_run, m_tick};
        check("model", {25'd0, bus.count, bus.direction, bus.running, bus.tick}, {25'd0, exp_v});
    endtask

    task automatic set_pins(input bit r, input bit d, input bit rn, input bit sn);
        rst = r; bus.dir_sw = d; bus.run_btn_n = rn; bus.step_btn_n = sn;
    endtask

    initial begin
        int ticks;
        int hold [3];
        bit pins [3];
        set_pins(1'b1, 1'b0, 1'b1, 1'b1);

        //       rst d  rn sn  n   cnt dir run tick
        add_vec(1, 0, 1, 1,  2,  0, 0, 1, 0);   // reset state
        add_vec(0, 0, 1, 1,  3,  0, 0, 1, 0);
        add_vec(0, 0, 1, 1,  1,  1, 0, 1, 1);   // first step at cycle 4
        add_vec(0, 0, 1, 1,  1,  1, 0, 1, 0);
        add_vec(0, 0, 1, 1,  3,  2, 0, 1, 1);   // cycle 8
        add_vec(0, 1, 1, 1,  4,  3, 0, 1, 1);   // dir_sw raised; step at 12 still up
        add_vec(0, 1, 1, 1,  1,  3, 1, 1, 0);   // direction 5 edges later, prescaler cleared
        add_vec(0, 1, 1, 1,  3,  3, 1, 1, 0);
        add_vec(0, 1, 1, 1,  1,  2, 1, 1, 1);   // full period after the change
        add_vec(0, 1, 1, 1,  4,  1, 1, 1, 1);
        add_vec(0, 1, 1, 1,  4,  0, 1, 1, 1);
        add_vec(0, 1, 1, 1,  4, 15, 1, 1, 1);   // 0 -> 15
        add_vec(0, 0, 1, 1,  2, 15, 1, 1, 0);   // 2-cycle glitch on dir_sw
        add_vec(0, 1, 1, 1,  2, 14, 1, 1, 1);
        add_vec(0, 1, 1, 1,  4, 13, 1, 1, 1);   // glitch ignored, cadence kept
        add_vec(0, 1, 0, 1,  6, 12, 1, 0, 0);   // pause press
        add_vec(0, 1, 1, 1, 40, 12, 1, 0, 0);   // frozen while paused
        add_vec(0, 1, 1, 0,  5, 11, 1, 0, 1);   // single step
        add_vec(0, 1, 1, 1,  1, 11, 1, 0, 0);
        add_vec(0, 1, 1, 1, 10, 11, 1, 0, 0);
        add_vec(0, 1, 0, 1,  5, 11, 1, 1, 0);   // resume press
        add_vec(0, 1, 1, 1,  2, 11, 1, 1, 0);
        add_vec(0, 1, 1, 1,  1, 10, 1, 1, 1);   // remaining held prescaler cycles
        add_vec(0, 1, 1, 0,  5,  9, 1, 1, 0);   // step press while running ignored
        add_vec(0, 1, 1, 1, 10,  7, 1, 1, 0);
        add_vec(0, 1, 0, 1,  5,  5, 1, 0, 1);   // pause press on terminal: step then pause
        add_vec(0, 1, 1, 1, 10,  5, 1, 0, 0);
        add_vec(0, 1, 0, 0,  5,  5, 1, 1, 0);   // run+step together: run wins, no step
        add_vec(0, 1, 1, 1,  4,  4, 1, 1, 1);
        add_vec(1, 1, 1, 1,  1,  0, 0, 1, 0);   // reset with dir_sw still high
        add_vec(0, 1, 1, 1,  4,  1, 0, 1, 1);
        add_vec(0, 1, 1, 1,  1,  1, 1, 1, 0);   // direction back 5 edges after reset
        add_vec(0, 1, 1, 1,  4,  0, 1, 1, 1);
        add_vec(0, 1, 1, 1,  4, 15, 1, 1, 1);

        foreach (vecs[i]) begin
            set_pins(vecs[i].rst, vecs[i].dir_sw, vecs[i].run_n, vecs[i].step_n);
            repeat (vecs[i].ncyc) cycle();
            check($sformatf("vec%0d", i),
                  {25'd0, bus.count, bus.direction, bus.running, bus.tick},
                  {25'd0, 4'(vecs[i].exp_count), vecs[i].exp_dir, vecs[i].exp_run, vecs[i].exp_tick});
        end

        // Full 16-step wrap from reset, counting ticks.
        set_pins(1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        set_pins(1'b0, 1'b0, 1'b1, 1'b1);
        ticks = 0;
        for (int c = 1; c <= 64; c++) begin
            cycle();
            if (bus.tick === 1'b1) ticks++;
            if (c == 60) check("wrap_15", {28'd0, bus.count}, 32'd15);
        end
        check("wrap_0", {28'd0, bus.count}, 32'd0);
        check("wrap_ticks", ticks, 16);

        // Random pin activity with occasional resets.
        for (int ch = 0; ch < 3; ch++) begin
            pins[ch] = idle_of(ch);
            hold[ch] = $urandom_range(1, 10);
        end
        for (int c = 0; c < 4000; c++) begin
            for (int ch = 0; ch < 3; ch++) begin
                hold[ch]--;
                if (hold[ch] <= 0) begin
                    pins[ch] = !pins[ch];
                    hold[ch] = (pins[ch] == idle_of(ch)) ? $urandom_range(1, 30)
                                                        : $urandom_range(1, 8);
                end
            end
            set_pins(($urandom_range(0, 299) == 0), pins[0], pins[1], pins[2]);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
